alu_control_sequencer: RTL and testbench
========================================

# alu_control_sequencer

Multi-cycle control sequencer that drives the datapath ALU. It fetches 32-bit instructions over a request/valid handshake and decodes them into ALUop, register-file addresses and an immediate. It steps each instruction through DECODE, EXECUTE and WRITEBACK, then advances the PC. It sits between instruction memory and the ALU/register-file datapath, acting as the producer of every ALUop code the ALU consumes.

## Interface
- No parameters.
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- en  input  1  run enable, sampled only in FETCH
- instr_req  output  1  instruction fetch request
- instr_addr  output  32  fetch address (= pc)
- instr_valid  input  1  instruction memory response strobe
- instr_data  input  32  instruction word, valid when instr_valid=1
- ALUop  output  3  ALU operation code
- alu_src_imm  output  1  1: ALU B operand = imm; 0: B = register rs2
- imm  output  32  zero-extended instr[13:0]
- rs1  output  5  register-file read address A
- rs2  output  5  register-file read address B
- rd  output  5  register-file write address
- reg_we  output  1  register-file write enable (one-cycle pulse)
- pc  output  32  program counter
- retired  output  16  count of completed instructions

## Operation
- Instruction format:
  - [31:29] opcode. It maps directly to ALUop: 000/001 NOOP, 010 ADD, 011 SUB, 100 SHL, 101 SHR, 110 ADDI, 111 SUBI.
  - [28:24] rd, [23:19] rs1, [18:14] rs2, [13:0] imm.
- FSM states are FETCH, DECODE, EXEC and WB. Reset state is FETCH.
- FETCH:
  - If en=1, assert instr_req with instr_addr=pc.
  - Hold instr_req until instr_valid=1.
  - On that cycle, latch instr_data into the internal IR and go to DECODE.
  - If en=0, instr_req=0 and the FSM stays in FETCH.
- DECODE (1 cycle): drive rs1, rs2, rd, imm and alu_src_imm from IR. alu_src_imm=1 only for opcodes 110/111. Go to EXEC.
- EXEC (1 cycle): drive ALUop=IR[31:29]. Go to WB.
- WB (1 cycle):
  - ALUop is held.
  - reg_we=1 unless opcode is 000/001 or rd==0.
  - pc <= pc+4, retired <= retired+1.
  - Go to FETCH.
- ALUop=000 in FETCH and DECODE. rs1/rs2/rd/imm/alu_src_imm are held from DECODE until the next DECODE.
- instr_valid is ignored outside FETCH and while instr_req=0.
- Dropping en mid-instruction does not stop the current instruction. It completes through WB and the FSM then parks in FETCH.
- pc wraps 0xFFFFFFFC -> 0x00000000. retired wraps 0xFFFF -> 0x0000.
- Opcodes 000 and 001 are both NOOP: no write, but the PC still advances and the instruction is counted.

## Timing
- Reset (async, takes effect immediately): state=FETCH, every output is 0, including pc, retired, ALUop, reg_we and instr_req. IR is cleared.
- After rst deassertion, instr_req rises on the first clock edge where en=1. It is combinational from state and en, so if en=1 it is high in the first cycle.
- Assertion during any state aborts the instruction with no reg_we pulse and no pc/retired update.
- Latency, counted from the cycle where instr_valid=1 is sampled:
  - DECODE is +1 cycle, EXEC +2, WB +3.
  - reg_we pulses in cycle +3.
  - pc/retired update at the end of cycle +3.
- Minimum throughput is 4 cycles per instruction, when instr_valid arrives in the first FETCH cycle.
- Handshake rule: instr_addr is stable while instr_req=1. The transfer occurs on the edge where instr_req and instr_valid are both 1.
- ALUop is stable across EXEC and WB, so the ALU Result is settled when reg_we writes it.

## Test plan
- Reset/idle: hold rst=1, then release with en=0 for 10 cycles. Required: instr_req=0, pc=0, retired=0, ALUop=000, reg_we=0 throughout.
- ADD, zero-wait memory: en=1, instr_data=0x4A110000 (ADD rd=10, rs1=2, rs2=4), instr_valid returned in the first FETCH cycle.
  - Required: rs1=2, rs2=4, rd=10, alu_src_imm=0.
  - ALUop=010 in EXEC and WB; reg_we=1 only in WB.
  - pc=4, retired=1; next instr_req has instr_addr=4.
- ADDI with wait states: valid delayed 3 cycles, instr_data=0xC3080123 (ADDI rd=3, rs1=1, imm=0x123).
  - Required: instr_req held and instr_addr stable for 4 cycles.
  - imm=0x00000123, alu_src_imm=1, ALUop=110, reg_we=1.
- NOOP and rd=0: issue opcode 001, then ADD with rd=0. Required: reg_we never asserted, pc advances by 8 total, retired increments by 2.
- Mid-operation events:
  - Drop en in EXEC. Required: WB still completes, then instr_req=0 in FETCH.
  - Assert rst in EXEC. Required: all outputs 0 immediately, no reg_we pulse, pc unchanged at 0.
- Wrap-around:
  - Force pc to 0xFFFFFFFC via a preloaded program. Required: after one instruction, pc=0x00000000.
  - After 65536 retired instructions, retired=0x0000.

Source files
------------

// File: rtl/alu_control_sequencer.sv
// alu_control_sequencer: multi-cycle FETCH/DECODE/EXEC/WB sequencer
// that fetches 32-bit words and issues ALUop and register-file controls.
//
// Ports:
//   clk, rst          clock, async active-high reset
//   en                run enable, looked at only in FETCH
//   instr_req/addr    fetch request and address (= pc)
//   instr_valid/data  fetch response strobe and instruction word
//   ALUop             ALU operation (non-zero only in EXEC and WB)
//   alu_src_imm       B operand select (1 = imm)
//   imm, rs1, rs2, rd decoded fields, held from DECODE to next DECODE
//   reg_we            register write pulse in WB
//   pc, retired       program counter and completed-instruction count
module alu_control_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        instr_req,
    output logic [31:0] instr_addr,
    input  logic        instr_valid,
    input  logic [31:0] instr_data,
    output logic [2:0]  ALUop,
    output logic        alu_src_imm,
    output logic [31:0] imm,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic        reg_we,
    output logic [31:0] pc,
    output logic [15:0] retired
);

    typedef enum logic [1:0] {
        FETCH,
        DECODE,
        EXEC,
        WB
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] ir;
    logic [31:0] pc_q;
    logic [15:0] ret_q;
    logic [2:0]  op;
    logic        take;
    logic        writes;

    // The IR only changes on a fetch transfer, so deriving the fields
    // straight from it holds them stable from DECODE to the next DECODE.
    assign op          = ir[31:29];
    assign rd          = ir[28:24];
    assign rs1         = ir[23:19];
    assign rs2         = ir[18:14];
    assign imm         = {18'd0, ir[13:0]};
    assign alu_src_imm = (op[2:1] == 2'b11);

    // Opcodes 000/001 are NOOPs; writes to r0 are suppressed.
    assign writes = (op[2:1] != 2'b00) && (rd != 5'd0);

    assign take       = instr_req && instr_valid;
    assign pc         = pc_q;
    assign instr_addr = pc_q;
    assign retired    = ret_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
            ir    <= 32'd0;
            pc_q  <= 32'd0;
            ret_q <= 16'd0;
        end else begin
            state <= state_nxt;
            if (take) begin
                ir <= instr_data;
            end
            if (state == WB) begin
                pc_q  <= pc_q + 32'd4;
                ret_q <= ret_q + 16'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        instr_req = 1'b0;
        ALUop     = 3'b000;
        reg_we    = 1'b0;
        unique case (state)
            FETCH: begin
                // Gated by rst so the request is low while reset is held.
                instr_req = en && !rst;
                if (en && !rst && instr_valid) begin
                    state_nxt = DECODE;
                end
            end
            DECODE: begin
                state_nxt = EXEC;
            end
            EXEC: begin
                ALUop     = op;
                state_nxt = WB;
            end
            WB: begin
                // ALUop held so the ALU result is settled for the write.
                ALUop     = op;
                reg_we    = writes;
                state_nxt = FETCH;
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_control_sequencer.sv
// tb_alu_control_sequencer: directed bench for alu_control_sequencer.
// Steps through reset, ADD/ADDI/NOOP, en drop, mid-run reset, wrap.
module tb_alu_control_sequencer;

    logic        clk;
    logic        rst;
    logic        en;
    logic        instr_req;
    logic [31:0] instr_addr;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [2:0]  ALUop;
    logic        alu_src_imm;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_we;
    logic [31:0] pc;
    logic [15:0] retired;

    int passed;
    int failed;
    int total;

    alu_control_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .instr_req   (instr_req),
        .instr_addr  (instr_addr),
        .instr_valid (instr_valid),
        .instr_data  (instr_data),
        .ALUop       (ALUop),
        .alu_src_imm (alu_src_imm),
        .imm         (imm),
        .rs1         (rs1),
        .rs2         (rs2),
        .rd          (rd),
        .reg_we      (reg_we),
        .pc          (pc),
        .retired     (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        passed      = 0;
        failed      = 0;
        total       = 0;
        rst         = 1'b1;
        en          = 1'b1;
        instr_valid = 1'b0;
        instr_data  = 32'd0;

        // Reset held, en=1: request must still be low
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_req", instr_req, 0);
        chk("rst_pc", pc, 0);
        chk("rst_ret", retired, 0);
        chk("rst_aluop", ALUop, 0);
        chk("rst_we", reg_we, 0);

        // Idle with en=0 for 10 cycles
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("idle_ctl", {instr_req, reg_we, ALUop}, 0);
            chk("idle_pc", pc, 0);
            chk("idle_ret", retired, 0);
            @(negedge clk);
        end

        // ADD r10 = r2 + r4, zero-wait memory
        en          = 1'b1;
        instr_valid = 1'b1;
        instr_data  = 32'h4A11_0000;
        #1;
        chk("add_req", instr_req, 1);
        chk("add_addr", instr_addr, 0);
        @(negedge clk);
        instr_valid = 1'b0;
        #1;
        chk("add_rs1", rs1, 2);
        chk("add_rs2", rs2, 4);
        chk("add_rd", rd, 10);
        chk("add_src", alu_src_imm, 0);
        chk("add_dec_op", ALUop, 0);
        chk("add_dec_we", reg_we, 0);
        chk("add_dec_req", instr_req, 0);
        @(negedge clk);
        #1;
        chk("add_ex_op", ALUop, 3'b010);
        chk("add_ex_we", reg_we, 0);
        @(negedge clk);
        #1;
        chk("add_wb_op", ALUop, 3'b010);
        chk("add_wb_we", reg_we, 1);
        chk("add_wb_pc", pc, 0);
        @(negedge clk);
        #1;
        chk("add_pc", pc, 4);
        chk("add_ret", retired, 1);
        chk("add_next_req", instr_req, 1);
        chk("add_next_addr", instr_addr, 4);
        chk("add_f_op", ALUop, 0);
        chk("add_f_we", reg_we, 0);

        // ADDI r3 = r1 + 0x123, valid after 3 wait cycles
        instr_data = 32'hC308_0123;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) instr_valid = 1'b1;
            chk("wait_req", instr_req, 1);
            chk("wait_addr", instr_addr, 4);
            if (i < 3) begin
                @(negedge clk);
                #1;
            end
        end
        @(negedge clk);
        instr_valid = 1'b0;
        #1;
        chk("addi_imm", imm, 32'h0000_0123);
        chk("addi_src", alu_src_imm, 1);
        chk("addi_rd", rd, 3);
        chk("addi_rs1", rs1, 1);
        @(negedge clk);
        #1;
        chk("addi_ex_op", ALUop, 3'b110);
        @(negedge clk);
        #1;
        chk("addi_wb_op", ALUop, 3'b110);
        chk("addi_wb_we", reg_we, 1);
        @(negedge clk);
        #1;
        chk("addi_pc", pc, 8);
        chk("addi_ret", retired, 2);

        // NOOP (opcode 001) then ADD with rd=0: no write at all
        for (int k = 0; k < 2; k++) begin
            instr_data  = (k == 0) ? 32'h2A11_0000 : 32'h4011_0000;
            instr_valid = 1'b1;
            for (int c = 0; c < 4; c++) begin
                chk("nowr_we", reg_we, 0);
                @(negedge clk);
                if (c == 0) instr_valid = 1'b0;
                #1;
            end
        end
        chk("nowr_pc", pc, 16);
        chk("nowr_ret", retired, 4);

        // Drop en in EXEC: instruction still completes
        instr_data  = 32'h4A11_0000;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        en = 1'b0;
        #1;
        chk("endrop_ex_op", ALUop, 3'b010);
        @(negedge clk);
        #1;
        chk("endrop_wb_we", reg_we, 1);
        @(negedge clk);
        #1;
        chk("endrop_req", instr_req, 0);
        chk("endrop_pc", pc, 20);
        chk("endrop_ret", retired, 5);
        @(negedge clk);
        #1;
        chk("endrop_park_req", instr_req, 0);
        chk("endrop_park_pc", pc, 20);

        // Reset asserted in EXEC
        en          = 1'b1;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("rstx_ex_op", ALUop, 3'b010);
        rst = 1'b1;
        #1;
        chk("rstx_ctl", {instr_req, reg_we, ALUop, alu_src_imm}, 0);
        chk("rstx_pc", pc, 0);
        chk("rstx_addr", instr_addr, 0);
        chk("rstx_ret", retired, 0);
        chk("rstx_fields", {rs1, rs2, rd}, 0);
        chk("rstx_imm", imm, 0);
        @(negedge clk);
        #1;
        chk("rstx_we", reg_we, 0);
        chk("rstx_pc_hold", pc, 0);
        en  = 1'b0;
        rst = 1'b0;

        // Wrap-around of pc and retired from preloaded values
        #1;
        force dut.pc_q  = 32'hFFFF_FFFC;
        force dut.ret_q = 16'hFFFF;
        #1;
        release dut.pc_q;
        release dut.ret_q;
        #1;
        chk("wrap_pre_addr", instr_addr, 32'hFFFF_FFFC);
        chk("wrap_pre_ret", retired, 16'hFFFF);
        @(negedge clk);
        en          = 1'b1;
        instr_valid = 1'b1;
        #1;
        chk("wrap_req_addr", instr_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("wrap_wb_we", reg_we, 1);
        @(negedge clk);
        #1;
        chk("wrap_pc", pc, 0);
        chk("wrap_ret", retired, 0);
        chk("wrap_addr", instr_addr, 0);
        en = 1'b0;

        if (failed != 0) $display("%0d checks did not pass", failed);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
